// File: rtl/hist_eq_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// hist_eq_pkg
//   Shared definitions for the histogram-equalisation stage sequencer:
//   the sequencer state encoding, default bus widths and the default
//   per-stage watchdog limit.
// ---------------------------------------------------------------------------
package hist_eq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_HIST  = 3'd2,
        ST_MAP   = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
    } seq_state_t;

    localparam int DEF_ADDR_W    = 16;
    localparam int DEF_DATA_W    = 128;
    localparam int DEF_CDF_W     = 20;
    localparam int DEF_CLR_WORDS = 256;
    localparam int DEF_TIMEOUT   = 2**20;

    // Watched stages: the only states with an external party that can hang.
    function automatic logic is_watched_stage(input seq_state_t st);
        return (st == ST_HIST) || (st == ST_MAP);
    endfunction

endpackage

// File: rtl/hist_eq_sequencer_if.sv
// ---------------------------------------------------------------------------
// hist_eq_sequencer_if
//   Pipeline-facing bundle of the sequencer: stage-1 (input_pipeline)
//   handshake, cdf result and m2 write request, the m2 SRAM write port,
//   and the stage-2 (mapping pipeline) handshake.
//   master : sequencer side
//   slave  : pipelines / SRAM side
// ---------------------------------------------------------------------------
interface hist_eq_sequencer_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 128,
    parameter int CDF_W  = 20
);
    logic              s1_start;
    logic              s1_done;
    logic [CDF_W-1:0]  s1_cdf_min;
    logic              s1_cdf_valid;
    logic              s1_m2WE;
    logic [ADDR_W-1:0] s1_m2WriteAddr;
    logic [DATA_W-1:0] s1_m2WriteBus;
    logic              m2WE;
    logic [ADDR_W-1:0] m2WriteAddr;
    logic [DATA_W-1:0] m2WriteBus;
    logic              s2_start;
    logic              s2_done;

    modport master (
        output s1_start,
        input  s1_done, s1_cdf_min, s1_cdf_valid,
        input  s1_m2WE, s1_m2WriteAddr, s1_m2WriteBus,
        output m2WE, m2WriteAddr, m2WriteBus,
        output s2_start,
        input  s2_done
    );

    modport slave (
        input  s1_start,
        output s1_done, s1_cdf_min, s1_cdf_valid,
        output s1_m2WE, s1_m2WriteAddr, s1_m2WriteBus,
        input  m2WE, m2WriteAddr, m2WriteBus,
        input  s2_start,
        output s2_done
    );
endinterface

// File: rtl/hist_eq_sequencer_watchdog.sv
// ---------------------------------------------------------------------------
// stage_watchdog
//   Cycle counter for a single pipeline stage.
//   clock   : system clock
//   rst     : synchronous active-high reset
//   clear   : zero the count at the next edge (stage left / not in a stage)
//   enable  : count one cycle at the next edge; saturates at TIMEOUT-1
//   expired : enable while the count already equals TIMEOUT-1, i.e. this is
//             the TIMEOUT-th cycle spent in the stage
// ---------------------------------------------------------------------------
module stage_watchdog #(
    parameter int TIMEOUT = 2**20
) (
    input  logic clock,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CNT_W = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] wd_cnt_reg;

    always_ff @(posedge clock) begin
        if (rst || clear) begin
            wd_cnt_reg <= '0;
        end else if (enable && (wd_cnt_reg != LIMIT)) begin
            wd_cnt_reg <= wd_cnt_reg + CNT_W'(1);
        end
    end

    assign expired = enable && (wd_cnt_reg == LIMIT);

endmodule

// File: rtl/hist_eq_sequencer.sv
// ---------------------------------------------------------------------------
// hist_eq_sequencer
//   Stage sequencer for the histogram-equalisation datapath. A rising edge
//   on start clears the first CLR_WORDS words of the m2 histogram SRAM,
//   runs input_pipeline (HIST) while capturing its cdf_min, then runs the
//   mapping pipeline (MAP). A watchdog aborts a stage that runs too long.
//   Ports:
//     clock, rst  : clock and synchronous active-high reset
//     start       : level run request, launches on its 0->1 edge
//     pipe        : pipeline handshakes and the m2 write port (master)
//     cdf_min     : latched cdf_min, valid from MAP entry until next run
//     busy/done/error : status decoded from the state register
// ---------------------------------------------------------------------------
module hist_eq_sequencer
    import hist_eq_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int CDF_W     = DEF_CDF_W,
    parameter int CLR_WORDS = DEF_CLR_WORDS,
    parameter int TIMEOUT   = DEF_TIMEOUT
) (
    input  logic                 clock,
    input  logic                 rst,
    input  logic                 start,
    hist_eq_sequencer_if.master  pipe,
    output logic [CDF_W-1:0]     cdf_min,
    output logic                 busy,
    output logic                 done,
    output logic                 error
);
    localparam logic [ADDR_W-1:0] LAST_CLR = ADDR_W'(CLR_WORDS - 1);

    seq_state_t        state_reg;
    logic [ADDR_W-1:0] clr_addr_reg;
    logic [CDF_W-1:0]  cdf_min_reg;
    logic              cdf_seen_reg;
    logic              start_q_reg;

    logic launch;
    logic wd_expired;
    logic wd_clear;
    logic in_stage;
    logic stage_exit;

    assign launch   = start && !start_q_reg;
    assign in_stage = is_watched_stage(state_reg);

    // A stage is left on its done or on timeout; the counter is held at zero
    // outside HIST/MAP, so every entry into a watched stage starts from 0.
    always_comb begin
        stage_exit = 1'b0;
        case (state_reg)
            ST_HIST: stage_exit = pipe.s1_done || wd_expired;
            ST_MAP:  stage_exit = pipe.s2_done || wd_expired;
            default: stage_exit = 1'b0;
        endcase
    end

    assign wd_clear = !in_stage || stage_exit;

    stage_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clock   (clock),
        .rst     (rst),
        .clear   (wd_clear),
        .enable  (in_stage),
        .expired (wd_expired)
    );

    always_ff @(posedge clock) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            clr_addr_reg <= '0;
            cdf_min_reg  <= '0;
            cdf_seen_reg <= 1'b0;
            start_q_reg  <= 1'b0;
        end else begin
            start_q_reg <= start;
            case (state_reg)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (launch) begin
                        state_reg    <= ST_CLEAR;
                        clr_addr_reg <= '0;
                        cdf_min_reg  <= '0;
                        cdf_seen_reg <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    clr_addr_reg <= clr_addr_reg + ADDR_W'(1);
                    if (clr_addr_reg == LAST_CLR) begin
                        state_reg <= ST_HIST;
                    end
                end
                ST_HIST: begin
                    if (pipe.s1_cdf_valid) begin
                        cdf_min_reg  <= pipe.s1_cdf_min;
                        cdf_seen_reg <= 1'b1;
                    end
                    // Done beats a coincident timeout.
                    if (pipe.s1_done) begin
                        state_reg <= (pipe.s1_cdf_valid || cdf_seen_reg) ? ST_MAP : ST_ERROR;
                    end else if (wd_expired) begin
                        state_reg <= ST_ERROR;
                    end
                end
                ST_MAP: begin
                    if (pipe.s2_done) begin
                        state_reg <= ST_DONE;
                    end else if (wd_expired) begin
                        state_reg <= ST_ERROR;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // m2 write port: counter-driven zero fill in CLEAR, zero-latency
    // passthrough of input_pipeline in HIST, idle otherwise.
    always_comb begin
        pipe.m2WE        = 1'b0;
        pipe.m2WriteAddr = '0;
        pipe.m2WriteBus  = '0;
        case (state_reg)
            ST_CLEAR: begin
                pipe.m2WE        = 1'b1;
                pipe.m2WriteAddr = clr_addr_reg;
            end
            ST_HIST: begin
                pipe.m2WE        = pipe.s1_m2WE;
                pipe.m2WriteAddr = pipe.s1_m2WriteAddr;
                pipe.m2WriteBus  = pipe.s1_m2WriteBus;
            end
            default: ;
        endcase
    end

    assign pipe.s1_start = (state_reg == ST_HIST);
    assign pipe.s2_start = (state_reg == ST_MAP);
    assign busy          = (state_reg == ST_CLEAR) || (state_reg == ST_HIST) || (state_reg == ST_MAP);
    assign done          = (state_reg == ST_DONE);
    assign error         = (state_reg == ST_ERROR);
    assign cdf_min       = cdf_min_reg;

endmodule
